// File: rtl/player_motion.sv
// rtl/player_motion.sv - four-player cursor motion with wrap-around and collision
module player_motion #(
   parameter int TICK_CYCLES = 833333,
   parameter int X_MAX       = 159,
   parameter int Y_MAX       = 119
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic [4:0]  KEY_PRESSED,
   output logic [17:0] p1,
   output logic [17:0] p2,
   output logic [17:0] p3,
   output logic [17:0] p4,
   output logic        step,
   output logic        game_over
);

   localparam int             CW       = $clog2(TICK_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_CYCLES - 1);
   localparam logic [7:0]     XM       = 8'(X_MAX);
   localparam logic [6:0]     YM       = 7'(Y_MAX);

   localparam logic [1:0] H_UP    = 2'd0;
   localparam logic [1:0] H_DOWN  = 2'd1;
   localparam logic [1:0] H_LEFT  = 2'd2;
   localparam logic [1:0] H_RIGHT = 2'd3;

   // reset values, player 0 in the low slice
   localparam logic [7:0]  RST_HD = {H_LEFT, H_RIGHT, H_LEFT, H_RIGHT};
   localparam logic [31:0] RST_X  = {8'd120, 8'd40, 8'd120, 8'd40};
   localparam logic [27:0] RST_Y  = {7'd90, 7'd90, 7'd30, 7'd30};

   typedef enum logic {RUN, OVER} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [1:0]    hd   [4];
   logic [1:0]    pend [4];
   logic [7:0]    xpos [4];
   logic [6:0]    ypos [4];
   logic [3:0]    alive;

   logic          tick;
   logic          key_ok;
   logic [3:0]    key_m1;
   logic [3:0]    rev;
   logic [1:0]    hd_nxt [4];
   logic [7:0]    x_nxt  [4];
   logic [6:0]    y_nxt  [4];
   logic [3:0]    hit;
   logic [2:0]    alive_cnt;

   assign tick      = (state == RUN) && (cnt == CNT_LAST);
   assign key_ok    = (state == RUN) && (KEY_PRESSED != 5'd0) && (KEY_PRESSED <= 5'd16);
   assign key_m1    = KEY_PRESSED[3:0] - 4'd1;
   assign alive_cnt = {2'b0, alive[0]} + {2'b0, alive[1]} + {2'b0, alive[2]} + {2'b0, alive[3]};
   assign game_over = (state == OVER);

   assign p1 = {hd[0], alive[0], xpos[0], ypos[0]};
   assign p2 = {hd[1], alive[1], xpos[1], ypos[1]};
   assign p3 = {hd[2], alive[2], xpos[2], ypos[2]};
   assign p4 = {hd[3], alive[3], xpos[3], ypos[3]};

   // resolve the heading each player would take at a tick and its wrapped next cell
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         rev[i]    = (pend[i] == (hd[i] ^ 2'b01));
         hd_nxt[i] = rev[i] ? hd[i] : pend[i];
         x_nxt[i]  = xpos[i];
         y_nxt[i]  = ypos[i];
         if (alive[i]) begin
            case (hd_nxt[i])
               H_UP:    y_nxt[i] = (ypos[i] == 7'd0) ? YM : ypos[i] - 7'd1;
               H_DOWN:  y_nxt[i] = (ypos[i] == YM) ? 7'd0 : ypos[i] + 7'd1;
               H_LEFT:  x_nxt[i] = (xpos[i] == 8'd0) ? XM : xpos[i] - 8'd1;
               default: x_nxt[i] = (xpos[i] == XM) ? 8'd0 : xpos[i] + 8'd1;
            endcase
         end
      end
   end

   // any pair of live players landing on the same cell kills both
   always_comb begin
      hit = 4'b0;
      for (int i = 0; i < 3; i++) begin
         for (int j = i + 1; j < 4; j++) begin
            if (alive[i] && alive[j] && (x_nxt[i] == x_nxt[j]) && (y_nxt[i] == y_nxt[j])) begin
               hit[i] = 1'b1;
               hit[j] = 1'b1;
            end
         end
      end
   end

   // game ends once the step that leaves at most one player alive is visible
   always_comb begin
      state_nxt = state;
      if ((state == RUN) && step && (alive_cnt <= 3'd1)) state_nxt = OVER;
   end

   // state register
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) state <= RUN;
      else         state <= state_nxt;
   end

   // tick counter, player registers and pending headings
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         cnt   <= '0;
         step  <= 1'b0;
         alive <= 4'hF;
         for (int i = 0; i < 4; i++) begin
            hd[i]   <= RST_HD[i*2 +: 2];
            pend[i] <= RST_HD[i*2 +: 2];
            xpos[i] <= RST_X[i*8 +: 8];
            ypos[i] <= RST_Y[i*7 +: 7];
         end
      end else begin
         step <= tick;
         if (state == RUN) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         if (tick) begin
            for (int i = 0; i < 4; i++) begin
               if (alive[i]) begin
                  hd[i]    <= hd_nxt[i];
                  xpos[i]  <= x_nxt[i];
                  ypos[i]  <= y_nxt[i];
                  alive[i] <= !hit[i];
                  if (rev[i]) pend[i] <= hd[i];
               end
            end
         end
         // a key in the tick cycle overrides the reversal reload and is used next tick
         if (key_ok) pend[key_m1[3:2]] <= key_m1[1:0];
      end
   end

endmodule

// File: tb/tb_player_motion.sv
// tb/tb_player_motion.sv - scoreboard bench for player_motion
module tb_player_motion;

   logic        CLOCK_50 = 1'b0;
   logic        resetn = 1'b0;
   logic [4:0]  KEY_PRESSED = 5'd0;
   logic [17:0] p1, p2, p3, p4;
   logic        step, game_over;

   int n_checks = 0;
   int n_fail   = 0;
   int n_step   = 0;

   typedef struct packed {
      logic [17:0] w1;
      logic [17:0] w2;
      logic [17:0] w3;
      logic [17:0] w4;
      logic        go;
   } exp_t;

   exp_t sb[$];

   player_motion #(.TICK_CYCLES(4), .X_MAX(159), .Y_MAX(119)) dut (
      .CLOCK_50    (CLOCK_50),
      .resetn      (resetn),
      .KEY_PRESSED (KEY_PRESSED),
      .p1          (p1),
      .p2          (p2),
      .p3          (p3),
      .p4          (p4),
      .step        (step),
      .game_over   (game_over)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   function automatic logic [17:0] mk(input int h, input int a, input int x, input int y);
      return {h[1:0], a[0], x[7:0], y[6:0]};
   endfunction

   task automatic check18(input string name, input logic [17:0] act, input logic [17:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got h%0d a%0d x%0d y%0d, expected h%0d a%0d x%0d y%0d", name,
                  act[17:16], act[15], act[14:7], act[6:0], exp[17:16], exp[15], exp[14:7], exp[6:0]);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // monitor: every step pulse pops one expected frame, game_over checked a cycle later
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLOCK_50);
         if (resetn && step) begin
            n_step++;
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_step %0d: got step=1, expected no step", n_step);
            end else begin
               e = sb.pop_front();
               check18($sformatf("step%0d_p1", n_step), p1, e.w1);
               check18($sformatf("step%0d_p2", n_step), p2, e.w2);
               check18($sformatf("step%0d_p3", n_step), p3, e.w3);
               check18($sformatf("step%0d_p4", n_step), p4, e.w4);
               @(negedge CLOCK_50);
               check1($sformatf("step%0d_game_over", n_step), game_over, e.go);
            end
         end
      end
   end

   // drive c0..c2 in the three cycles before a tick and c3 in the tick cycle itself
   task automatic tick(input logic [4:0] c0, input logic [4:0] c1, input logic [4:0] c2,
                       input logic [4:0] c3, input logic [17:0] e1, input logic [17:0] e2,
                       input logic [17:0] e3, input logic [17:0] e4, input logic go);
      exp_t e;
      logic got;
      e = {e1, e2, e3, e4, go};
      sb.push_back(e);
      KEY_PRESSED = c0; @(negedge CLOCK_50);
      KEY_PRESSED = c1; @(negedge CLOCK_50);
      KEY_PRESSED = c2; @(negedge CLOCK_50);
      KEY_PRESSED = c3;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge CLOCK_50);
         if (step) got = 1'b1;
      end
      KEY_PRESSED = 5'd0;
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL step_timeout: got no step in 8 cycles, expected a step");
         void'(sb.pop_back());
      end
   endtask

   task automatic do_reset();
      @(negedge CLOCK_50);
      resetn = 1'b0;
      KEY_PRESSED = 5'd0;
      @(negedge CLOCK_50);
      resetn = 1'b1;
      check18("rst_p1", p1, mk(3, 1, 40, 30));
      check18("rst_p2", p2, mk(2, 1, 120, 30));
      check18("rst_p3", p3, mk(3, 1, 40, 90));
      check18("rst_p4", p4, mk(2, 1, 120, 90));
      check1("rst_step", step, 1'b0);
      check1("rst_game_over", game_over, 1'b0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic got_step;
      repeat (3) @(negedge CLOCK_50);
      do_reset();

      // default motion, turn, reversal, key in tick cycle, illegal code
      tick(0, 0, 0, 0, mk(3,1,41,30), mk(2,1,119,30), mk(3,1,41,90), mk(2,1,119,90), 0);
      tick(0, 0, 0, 0, mk(3,1,42,30), mk(2,1,118,30), mk(3,1,42,90), mk(2,1,118,90), 0);
      tick(0, 0, 0, 0, mk(3,1,43,30), mk(2,1,117,30), mk(3,1,43,90), mk(2,1,117,90), 0);
      tick(1, 0, 0, 0, mk(0,1,43,29), mk(2,1,116,30), mk(3,1,44,90), mk(2,1,116,90), 0);
      tick(2, 0, 0, 0, mk(0,1,43,28), mk(2,1,115,30), mk(3,1,45,90), mk(2,1,115,90), 0);
      tick(0, 0, 0, 3, mk(0,1,43,27), mk(2,1,114,30), mk(3,1,46,90), mk(2,1,114,90), 0);
      tick(0, 0, 0, 0, mk(2,1,42,27), mk(2,1,113,30), mk(3,1,47,90), mk(2,1,113,90), 0);
      tick(20, 0, 0, 0, mk(2,1,41,27), mk(2,1,112,30), mk(3,1,48,90), mk(2,1,112,90), 0);

      // all four wrap: p1/p3 up, p4 down, p2 left through x=0
      do_reset();
      for (int k = 1; k <= 122; k++)
         tick((k == 1) ? 5'd1 : 5'd0, (k == 1) ? 5'd9 : 5'd0, (k == 1) ? 5'd14 : 5'd0, 5'd0,
              mk(0, 1, 40, (k <= 30) ? 30 - k : 150 - k),
              mk(2, 1, (k <= 120) ? 120 - k : 280 - k, 30),
              mk(0, 1, 40, (k <= 90) ? 90 - k : 210 - k),
              mk(1, 1, 120, (k <= 29) ? 90 + k : k - 30), 1'b0);

      // p1 and p2 collide at (80,30); p3 and p4 keep going
      do_reset();
      for (int k = 1; k <= 45; k++)
         tick((k == 1) ? 5'd9 : 5'd0, (k == 1) ? 5'd14 : 5'd0, 5'd0, 5'd0,
              (k < 40) ? mk(3, 1, 40 + k, 30) : mk(3, 0, 80, 30),
              (k < 40) ? mk(2, 1, 120 - k, 30) : mk(2, 0, 80, 30),
              mk(0, 1, 40, 90 - k),
              mk(1, 1, 120, (k <= 29) ? 90 + k : k - 30), 1'b0);

      // four-way simultaneous collision ends the game
      do_reset();
      for (int k = 1; k <= 40; k++)
         tick(0, 0, 0, 0,
              mk(3, (k < 40) ? 1 : 0, (k < 40) ? 40 + k : 80, 30),
              mk(2, (k < 40) ? 1 : 0, (k < 40) ? 120 - k : 80, 30),
              mk(3, (k < 40) ? 1 : 0, (k < 40) ? 40 + k : 80, 90),
              mk(2, (k < 40) ? 1 : 0, (k < 40) ? 120 - k : 80, 90), (k == 40));

      got_step = 1'b0;
      for (int c = 0; c < 80; c++) begin
         KEY_PRESSED = 5'((c % 16) + 1);
         @(negedge CLOCK_50);
         got_step = got_step | step;
      end
      KEY_PRESSED = 5'd0;
      check1("over_no_step", got_step, 1'b0);
      check18("over_p1", p1, mk(3, 0, 80, 30));
      check18("over_p2", p2, mk(2, 0, 80, 30));
      check18("over_p3", p3, mk(3, 0, 80, 90));
      check18("over_p4", p4, mk(2, 0, 80, 90));
      check1("over_game_over", game_over, 1'b1);

      // reset from OVER restores everything and motion restarts
      do_reset();
      tick(0, 0, 0, 0, mk(3,1,41,30), mk(2,1,119,30), mk(3,1,41,90), mk(2,1,119,90), 0);

      for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge CLOCK_50);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
